lb_arbiter: RTL and testbench

//  Two-master arbiter for the 24-bit-address / 32-bit-data local bus that drives the cryomodule

---
 rtl/lb_pkg.sv | 19 +
 rtl/lb_tag_pipe.sv | 37 +++
 rtl/lb_arbiter.sv | 135 +++++++++++++
 tb/tb_lb_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared local-bus definitions: bus widths, master identifiers and the request bundle
// that the arbiter selects between.
package lb_pkg;

   localparam int LB_AW = 24;
   localparam int LB_DW = 32;

   typedef enum logic {
      MST_0 = 1'b0,
      MST_1 = 1'b1
   } mst_id_e;

   typedef struct packed {
      logic             rd;
      logic [LB_AW-1:0] addr;
      logic [LB_DW-1:0] wdata;
   } lb_req_t;

endpackage

// File: rtl/lb_tag_pipe.sv
// Fixed-depth {valid, id} delay line carrying read ownership alongside the bus read
// latency; flush drops every in-flight tag on the next edge.
module lb_tag_pipe
   import lb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    flush,
   input  logic    in_valid,
   input  mst_id_e in_id,
   output logic    out_valid,
   output mst_id_e out_id
);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] id_q, id_d;

   always_comb begin
      valid_d = {valid_q[DEPTH-2:0], in_valid};
      id_d    = {id_q[DEPTH-2:0], in_id};
   end

   // Only the valid bits need clearing; a stale id is harmless without its valid.
   always_ff @(posedge clk) begin
      if (flush) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
      id_q <= id_d;
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_id    = mst_id_e'(id_q[DEPTH-1]);

endmodule

// File: rtl/lb_arbiter.sv
// Two-master local-bus arbiter: grants one request per cycle, registers it onto the
// shared bus and steers pipelined read data back to the master that issued the read.
module lb_arbiter
   import lb_pkg::*;
#(
   parameter int AW       = LB_AW,
   parameter int DW       = LB_DW,
   parameter int READ_LAT = 3,
   parameter bit M0_PRIO  = 1'b1
) (
   input  logic          lb_clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_rd,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_rd,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] lb_addr,
   output logic [DW-1:0] lb_dout,
   output logic          lb_write,
   output logic          lb_read,
   input  logic [DW-1:0] lb_din
);

   lb_req_t m0_bus, m1_bus, win;
   mst_id_e win_id;
   logic    issue;

   mst_id_e last_q, last_d;
   logic [AW-1:0] lb_addr_q, lb_addr_d;
   logic [DW-1:0] lb_dout_q, lb_dout_d;
   logic lb_write_q, lb_write_d;
   logic lb_read_q, lb_read_d;
   logic m0_rvalid_q, m0_rvalid_d;
   logic m1_rvalid_q, m1_rvalid_d;
   logic [DW-1:0] m0_rdata_q, m0_rdata_d;
   logic [DW-1:0] m1_rdata_q, m1_rdata_d;

   logic    tag_valid;
   mst_id_e tag_id;

   assign m0_bus = '{rd: m0_rd, addr: m0_addr, wdata: m0_wdata};
   assign m1_bus = '{rd: m1_rd, addr: m1_addr, wdata: m1_wdata};

   // Master 0 wins a collision outright in priority mode, otherwise whoever was not served last.
   always_comb begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      if (!rst) begin
         if (m0_req && m1_req) begin
            if (M0_PRIO || last_q == MST_1) begin
               m0_gnt = 1'b1;
            end else begin
               m1_gnt = 1'b1;
            end
         end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
         end
      end
   end

   always_comb begin
      win        = m1_gnt ? m1_bus : m0_bus;
      win_id     = m1_gnt ? MST_1 : MST_0;
      issue      = m0_gnt | m1_gnt;
      lb_addr_d  = issue ? win.addr : lb_addr_q;
      lb_dout_d  = issue ? win.wdata : lb_dout_q;
      lb_write_d = issue & ~win.rd;
      lb_read_d  = issue & win.rd;
      last_d     = issue ? win_id : last_q;
   end

   // One extra stage beyond READ_LAT lines the tag up with lb_din on the bus.
   lb_tag_pipe #(
      .DEPTH(READ_LAT + 1)
   ) u_tag_pipe (
      .clk      (lb_clk),
      .flush    (rst),
      .in_valid (lb_read_d),
      .in_id    (win_id),
      .out_valid(tag_valid),
      .out_id   (tag_id)
   );

   always_comb begin
      m0_rvalid_d = tag_valid && (tag_id == MST_0);
      m1_rvalid_d = tag_valid && (tag_id == MST_1);
      m0_rdata_d  = m0_rvalid_d ? lb_din : m0_rdata_q;
      m1_rdata_d  = m1_rvalid_d ? lb_din : m1_rdata_q;
   end

   always_ff @(posedge lb_clk) begin
      if (rst) begin
         last_q      <= MST_1;
         lb_addr_q   <= '0;
         lb_dout_q   <= '0;
         lb_write_q  <= 1'b0;
         lb_read_q   <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         last_q      <= last_d;
         lb_addr_q   <= lb_addr_d;
         lb_dout_q   <= lb_dout_d;
         lb_write_q  <= lb_write_d;
         lb_read_q   <= lb_read_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
      end
   end

   assign lb_addr   = lb_addr_q;
   assign lb_dout   = lb_dout_q;
   assign lb_write  = lb_write_q;
   assign lb_read   = lb_read_q;
   assign m0_rvalid = m0_rvalid_q;
   assign m1_rvalid = m1_rvalid_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_lb_arbiter.sv
// Bench for lb_arbiter: a round-robin and a master-0-priority instance share stimulus;
// each is compared every cycle against a cycle-scheduled behavioural model of the bus.
module tb_lb_arbiter;

   localparam int RL = 3;

   logic lb_clk = 1'b0;
   always #5 lb_clk = ~lb_clk;

   logic        rst;
   logic        m0_req, m0_rd, m1_req, m1_rd;
   logic [23:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;

   logic [1:0]       o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_lb_write, o_lb_read;
   logic [1:0][31:0] o_m0_rdata, o_m1_rdata, o_lb_dout, din;
   logic [1:0][23:0] o_lb_addr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit model_ok = 1'b0;

   // Behavioural model state, index 0 = round-robin instance, 1 = priority instance.
   bit          m_last [2];
   logic [23:0] m_addr [2];
   logic [31:0] m_dout [2];
   bit          m_wr [2], m_rd [2], m_rv0 [2], m_rv1 [2];
   logic [31:0] m_rdata0 [2], m_rdata1 [2];
   bit          s_v [2][64];
   bit          s_id [2][64];
   logic [31:0] s_data [2][64];

   bit ob_g0 [2], ob_g1 [2], ob_rv0 [2], ob_rv1 [2];

   lb_arbiter #(.AW(24), .DW(32), .READ_LAT(RL), .M0_PRIO(1'b0)) dut_rr (
      .lb_clk(lb_clk), .rst(rst),
      .m0_req(m0_req), .m0_rd(m0_rd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(o_m0_gnt[0]), .m0_rvalid(o_m0_rvalid[0]), .m0_rdata(o_m0_rdata[0]),
      .m1_req(m1_req), .m1_rd(m1_rd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(o_m1_gnt[0]), .m1_rvalid(o_m1_rvalid[0]), .m1_rdata(o_m1_rdata[0]),
      .lb_addr(o_lb_addr[0]), .lb_dout(o_lb_dout[0]), .lb_write(o_lb_write[0]),
      .lb_read(o_lb_read[0]), .lb_din(din[0])
   );

   lb_arbiter #(.AW(24), .DW(32), .READ_LAT(RL), .M0_PRIO(1'b1)) dut_pr (
      .lb_clk(lb_clk), .rst(rst),
      .m0_req(m0_req), .m0_rd(m0_rd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(o_m0_gnt[1]), .m0_rvalid(o_m0_rvalid[1]), .m0_rdata(o_m0_rdata[1]),
      .m1_req(m1_req), .m1_rd(m1_rd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(o_m1_gnt[1]), .m1_rvalid(o_m1_rvalid[1]), .m1_rdata(o_m1_rdata[1]),
      .lb_addr(o_lb_addr[1]), .lb_dout(o_lb_dout[1]), .lb_write(o_lb_write[1]),
      .lb_read(o_lb_read[1]), .lb_din(din[1])
   );

   function automatic logic [31:0] bus_data(input logic [23:0] a);
      if (a == 24'h000010) return 32'hCAFE0001;
      return {a[15:0] ^ 16'h5A5A, a[23:8]};
   endfunction

   // Bus slave: read data appears exactly RL cycles after the lb_read strobe.
   logic [31:0] bpipe [2][RL];
   always @(posedge lb_clk) begin
      for (int i = 0; i < 2; i++) begin
         bpipe[i][0] <= o_lb_read[i] ? bus_data(o_lb_addr[i]) : 32'h0BAD0BAD;
         for (int k = 1; k < RL; k++) bpipe[i][k] <= bpipe[i][k-1];
      end
   end
   assign din[0] = bpipe[0][RL-1];
   assign din[1] = bpipe[1][RL-1];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Drives one cycle of inputs, checks both instances, advances the model past the edge.
   task automatic applyStimulus(input logic r,
                                input logic q0, input logic rd0, input logic [23:0] a0, input logic [31:0] w0,
                                input logic q1, input logic rd1, input logic [23:0] a1, input logic [31:0] w1);
      rst = r;
      m0_req = q0; m0_rd = rd0; m0_addr = a0; m0_wdata = w0;
      m1_req = q1; m1_rd = rd1; m1_addr = a1; m1_wdata = w1;
      #2;
      for (int i = 0; i < 2; i++) begin
         int w;
         int slot;
         string pre;
         logic [23:0] wa;
         logic [31:0] wd;
         logic wrd;
         w = -1;
         pre = (i == 0) ? "rr" : "pr";
         if (!r) begin
            if (q0 && q1) w = (i == 1 || m_last[i]) ? 0 : 1;
            else if (q0) w = 0;
            else if (q1) w = 1;
         end
         ob_g0[i] = o_m0_gnt[i];
         ob_g1[i] = o_m1_gnt[i];
         ob_rv0[i] = o_m0_rvalid[i];
         ob_rv1[i] = o_m1_rvalid[i];
         checkOutput($sformatf("%s.m0_gnt", pre), 32'(o_m0_gnt[i]), 32'(w == 0));
         checkOutput($sformatf("%s.m1_gnt", pre), 32'(o_m1_gnt[i]), 32'(w == 1));
         if (model_ok) begin
            checkOutput($sformatf("%s.lb_addr", pre), 32'(o_lb_addr[i]), 32'(m_addr[i]));
            checkOutput($sformatf("%s.lb_dout", pre), o_lb_dout[i], m_dout[i]);
            checkOutput($sformatf("%s.lb_write", pre), 32'(o_lb_write[i]), 32'(m_wr[i]));
            checkOutput($sformatf("%s.lb_read", pre), 32'(o_lb_read[i]), 32'(m_rd[i]));
            checkOutput($sformatf("%s.m0_rvalid", pre), 32'(o_m0_rvalid[i]), 32'(m_rv0[i]));
            checkOutput($sformatf("%s.m1_rvalid", pre), 32'(o_m1_rvalid[i]), 32'(m_rv1[i]));
            checkOutput($sformatf("%s.m0_rdata", pre), o_m0_rdata[i], m_rdata0[i]);
            checkOutput($sformatf("%s.m1_rdata", pre), o_m1_rdata[i], m_rdata1[i]);
         end
         if (r) begin
            m_last[i] = 1'b1;
            m_addr[i] = '0; m_dout[i] = '0; m_wr[i] = 1'b0; m_rd[i] = 1'b0;
            m_rv0[i] = 1'b0; m_rv1[i] = 1'b0; m_rdata0[i] = '0; m_rdata1[i] = '0;
            for (int k = 0; k < 64; k++) s_v[i][k] = 1'b0;
         end else begin
            slot = (cyc + 1) % 64;
            m_rv0[i] = 1'b0;
            m_rv1[i] = 1'b0;
            if (s_v[i][slot]) begin
               s_v[i][slot] = 1'b0;
               if (s_id[i][slot]) begin m_rv1[i] = 1'b1; m_rdata1[i] = s_data[i][slot]; end
               else begin m_rv0[i] = 1'b1; m_rdata0[i] = s_data[i][slot]; end
            end
            m_wr[i] = 1'b0;
            m_rd[i] = 1'b0;
            if (w >= 0) begin
               wa = (w == 1) ? a1 : a0;
               wd = (w == 1) ? w1 : w0;
               wrd = (w == 1) ? rd1 : rd0;
               m_addr[i] = wa; m_dout[i] = wd; m_wr[i] = !wrd; m_rd[i] = wrd;
               m_last[i] = (w == 1);
               if (wrd) begin
                  slot = (cyc + RL + 2) % 64;
                  s_v[i][slot] = 1'b1; s_id[i][slot] = (w == 1); s_data[i][slot] = bus_data(wa);
               end
            end
         end
      end
      if (r) model_ok = 1'b1;
      @(posedge lb_clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 24'h0, 32'h0, 0, 0, 24'h0, 32'h0);
   endtask

   // Issues one master-0 read and measures when and what comes back, bounded to 10 cycles.
   task automatic readLatency(input logic [23:0] a, input logic [31:0] expd, input string tag);
      int ret_at;
      int m1cnt;
      logic [31:0] rdat;
      ret_at = -1; m1cnt = 0; rdat = '0;
      applyStimulus(0, 1, 1, a, 32'h0, 0, 0, 24'h0, 32'h0);
      checkOutput({tag, "_gnt"}, 32'(ob_g0[0]), 1);
      for (int k = 1; k <= 10; k++) begin
         idle(1);
         if (ob_rv0[0] && ret_at < 0) begin ret_at = k; rdat = o_m0_rdata[0]; end
         if (ob_rv1[0]) m1cnt++;
      end
      checkOutput({tag, "_latency"}, ret_at, RL + 2);
      checkOutput({tag, "_rdata"}, rdat, expd);
      checkOutput({tag, "_m1_quiet"}, m1cnt, 0);
   endtask

   initial begin
      bit g0rr [6];
      bit g1rr [6];
      int pr0, pr1, first, last_k, c0, c1, stray;
      $display("[TB] lb_arbiter bench start, READ_LAT=%0d", RL);

      // Reset with master 0 requesting, then first grant once rst drops.
      repeat (3) applyStimulus(1, 1, 1, 24'h0, 32'h0, 0, 0, 24'h0, 32'h0);
      applyStimulus(0, 1, 0, 24'h000100, 32'h11111111, 0, 0, 24'h0, 32'h0);
      checkOutput("t1_first_gnt_rr", 32'(ob_g0[0]), 1);
      checkOutput("t1_first_gnt_pr", 32'(ob_g0[1]), 1);
      idle(2);

      // Single write from master 1.
      applyStimulus(0, 0, 0, 24'h0, 32'h0, 1, 0, 24'h010040, 32'hDEADBEEF);
      checkOutput("t2_write", 32'(o_lb_write[0]), 1);
      checkOutput("t2_addr", 32'(o_lb_addr[0]), 32'h00010040);
      checkOutput("t2_dout", o_lb_dout[0], 32'hDEADBEEF);
      idle(1);
      checkOutput("t2_write_once", 32'(o_lb_write[0]), 0);
      idle(6);

      // Read latency.
      readLatency(24'h000010, 32'hCAFE0001, "t3");

      // Collision.
      applyStimulus(1, 0, 0, 24'h0, 32'h0, 0, 0, 24'h0, 32'h0);
      pr0 = 0; pr1 = 0;
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, 1, 0, 24'h000020 + 24'(k), 32'hA0000000 + k, 1, 0, 24'h000030 + 24'(k), 32'hB0000000 + k);
         g0rr[k] = ob_g0[0]; g1rr[k] = ob_g1[0];
         pr0 += int'(ob_g0[1]); pr1 += int'(ob_g1[1]);
      end
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("t4_rr_gnt0_%0d", k), 32'(g0rr[k]), 32'((k % 2) == 0));
         checkOutput($sformatf("t4_rr_gnt1_%0d", k), 32'(g1rr[k]), 32'((k % 2) == 1));
      end
      checkOutput("t4_pr_m0_count", pr0, 6);
      checkOutput("t4_pr_m1_count", pr1, 0);
      idle(2);

      // Interleaved reads on four consecutive cycles.
      first = -1; last_k = -1; c0 = 0; c1 = 0;
      for (int j = 0; j < 14; j++) begin
         case (j)
            0: applyStimulus(0, 1, 1, 24'h000200, 32'h0, 0, 0, 24'h0, 32'h0);
            1: applyStimulus(0, 0, 0, 24'h0, 32'h0, 1, 1, 24'h000300, 32'h0);
            2: applyStimulus(0, 1, 1, 24'h000204, 32'h0, 0, 0, 24'h0, 32'h0);
            3: applyStimulus(0, 0, 0, 24'h0, 32'h0, 1, 1, 24'h000304, 32'h0);
            default: idle(1);
         endcase
         if (ob_rv0[0] || ob_rv1[0]) begin
            if (first < 0) first = j;
            last_k = j;
         end
         c0 += int'(ob_rv0[0]); c1 += int'(ob_rv1[0]);
      end
      checkOutput("t5_first_return", first, RL + 2);
      checkOutput("t5_last_return", last_k, RL + 5);
      checkOutput("t5_m0_pulses", c0, 2);
      checkOutput("t5_m1_pulses", c1, 2);

      // Reset while a read is in flight.
      applyStimulus(0, 1, 1, 24'h000400, 32'h0, 0, 0, 24'h0, 32'h0);
      idle(2);
      repeat (2) applyStimulus(1, 0, 0, 24'h0, 32'h0, 0, 0, 24'h0, 32'h0);
      stray = 0;
      for (int k = 0; k < 10; k++) begin
         idle(1);
         stray += int'(ob_rv0[0]) + int'(ob_rv1[0]) + int'(ob_rv0[1]) + int'(ob_rv1[1]);
      end
      checkOutput("t6_no_rvalid_after_flush", stray, 0);
      readLatency(24'h000010, 32'hCAFE0001, "t6");

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         applyStimulus(($urandom_range(0, 49) == 0),
                       ($urandom_range(0, 2) != 0), 1'($urandom), 24'($urandom), $urandom,
                       ($urandom_range(0, 2) != 0), 1'($urandom), 24'($urandom), $urandom);
      end
      idle(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
